conv_engine: RTL and testbench
==============================

CONV_ENGINE -- requirements
Module: conv_engine

Interface
REQ-001 SHALL have parameter BIT_DEPTH, default 8, pixel and output width.
REQ-002 SHALL have parameter KSIZE, default 3, square kernel edge K.
REQ-003 SHALL have parameter IMG_WIDTH, default 28, columns per band W.
REQ-004 SHALL have parameter ADDR_W, default 5, destination address width.
REQ-005 SHALL have local ACC_W = 2*BIT_DEPTH + clog2(K*K) + 1, signed accumulator width.
REQ-006 clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  begin one band; sampled only in IDLE.
REQ-009 stride  in  2  value 2 means stride 2; any other value means stride 1; latched at start.
REQ-010 pool_en  in  1  horizontal 2:1 max-pool of results; latched at start.
REQ-011 relu_en  in  1  ReLU/unsigned clamp select; latched at start.
REQ-012 in_dest_addr  in  ADDR_W  first output address; latched at start.
REQ-013 in_col  in  K*BIT_DEPTH  one column of K unsigned pixels; row r at bits [r*B +: B].
REQ-014 in_valid / in_ready  in / out  1  column handshake; transfer when both high.
REQ-015 kernel_addr  out  clog2(K*K)  kernel tap index to external ROM.
REQ-016 kernel_in  in  BIT_DEPTH  signed tap weight for the current kernel_addr, same cycle.
REQ-017 out_data  out  BIT_DEPTH  result; out_addr  out  ADDR_W  destination address.
REQ-018 out_valid / out_ready  out / in  1  result handshake.
REQ-019 busy  out  1  high in any state except IDLE; done  out  1  one-cycle completion pulse.

Function
REQ-020 SHALL implement states IDLE, FILL, MAC, WRITE, DONE.
REQ-021 IDLE->FILL on start; start in any other state SHALL be ignored.
REQ-022 in_ready SHALL be 1 only in FILL; each transfer shifts in_col into a K-column window, oldest column = col 0.
REQ-023 FILL->MAC after K transfers for the first window of a band, after S transfers (S = 1 or 2) for each later window.
REQ-024 MAC SHALL last exactly K*K cycles; kernel_addr = t for t = 0..K*K-1 in row-major order (tap t = row t/K, col t%K); acc += pixel * kernel_in.
REQ-025 Pixel zero-extended, weight sign-extended to ACC_W; acc cleared on entry to MAC; no overflow possible at ACC_W.
REQ-026 Post-process: relu_en=1 clamps to [0, 2^B-1]; relu_en=0 saturates to signed [-2^(B-1), 2^(B-1)-1], two's complement.
REQ-027 Window count N = (W-K)/S + 1, integer division.
REQ-028 pool_en=0: every result goes to WRITE; pool_en=1: even-index result held, odd-index result -> WRITE with max(held, current), compared in output encoding; unpaired final result SHALL be discarded; non-emitting windows go MAC->FILL.
REQ-029 WRITE: out_valid high, out_data/out_addr stable until out_ready; on handshake out_addr increments by 1 (wraps modulo 2^ADDR_W).
REQ-030 After last window's MAC/WRITE completes, SHALL go to DONE; done=1 for exactly one cycle, then IDLE.
REQ-031 Latency from last column transfer of a window to out_valid SHALL be K*K+1 cycles.
REQ-032 in_valid outside FILL and out_ready outside WRITE SHALL have no effect.

Reset
REQ-033 rst low asynchronously forces IDLE; in_ready, out_valid, done, busy, kernel_addr, out_data, acc, window, counters SHALL be 0; out_addr SHALL be 0.
REQ-034 Reset asserted mid-band SHALL abandon the band; no out_valid after release until a new start.

Verification
REQ-035 K=3, W=8, S=1, relu_en=1, all pixels 1, all weights 1, dest 4 -> six outputs of 9 at addresses 4..9, then done pulse.
REQ-036 Same, stride=2 -> three outputs of 9 at addresses 4..6.
REQ-037 Pixels 255, weights 127 -> 255 (relu_en=1); weights -1 (sum -2295) -> 0 with relu_en=1, 0x80 with relu_en=0.
REQ-038 pool_en=1, S=1, pixel value = column index c, weights 1 -> raw 9,18,27,36,45,54; emitted 18,36,54 at dest..dest+2.
REQ-039 out_ready low 5 cycles during WRITE -> out_valid, out_data, out_addr constant, in_ready 0; completes on out_ready high.
REQ-040 rst low during MAC cycle 4 -> all outputs 0 next edge; after release, no activity until start.

Source files
------------

// File: rtl/conv_engine.sv
// Streaming KxK convolution over a band of K-row pixel columns: windowed MAC against an
// external kernel ROM, ReLU or signed saturation, optional 2:1 horizontal max-pool.
//
// state | meaning
// IDLE  | waiting for start, configuration latched on start
// FILL  | accepting columns into the K-column window
// MAC   | K*K multiply-accumulate cycles, one kernel tap per cycle
// WRITE | presenting a result until out_ready
// DONE  | one-cycle completion pulse
module conv_engine #(
   parameter int BIT_DEPTH = 8,
   parameter int KSIZE     = 3,
   parameter int IMG_WIDTH = 28,
   parameter int ADDR_W    = 5,
   localparam int KK = KSIZE * KSIZE,
   localparam int TW = (KK > 1) ? $clog2(KK) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [1:0]                 stride,
   input  logic                       pool_en,
   input  logic                       relu_en,
   input  logic [ADDR_W-1:0]          in_dest_addr,
   input  logic [KSIZE*BIT_DEPTH-1:0] in_col,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [TW-1:0]              kernel_addr,
   input  logic [BIT_DEPTH-1:0]       kernel_in,
   output logic [BIT_DEPTH-1:0]       out_data,
   output logic [ADDR_W-1:0]          out_addr,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       busy,
   output logic                       done
);

   localparam int ACC_W = 2 * BIT_DEPTH + $clog2(KK) + 1;
   localparam int RW    = (KSIZE > 1) ? $clog2(KSIZE) : 1;
   localparam int FW    = $clog2(KSIZE + 1);
   localparam int WW    = $clog2(IMG_WIDTH + 2);
   localparam int N1    = IMG_WIDTH - KSIZE + 1;
   localparam int N2    = (IMG_WIDTH - KSIZE) / 2 + 1;
   localparam logic signed [ACC_W-1:0] UMAX = ACC_W'((1 << BIT_DEPTH) - 1);
   localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((1 << (BIT_DEPTH - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;

   typedef enum logic [2:0] {S_IDLE, S_FILL, S_MAC, S_WRITE, S_DONE} state_t;

   state_t                     state, state_nxt;
   logic [KSIZE*BIT_DEPTH-1:0] win_col [KSIZE];
   logic signed [ACC_W-1:0]    acc;
   logic [RW-1:0]              tap_r, tap_c;
   logic [FW-1:0]              fill_cnt, need_m1;
   logic [WW-1:0]              win_idx, n_win;
   logic                       s2_q, pool_q, relu_q;
   logic [BIT_DEPTH-1:0]       held, res, pooled, pix;
   logic signed [ACC_W-1:0]    pix_ext, wt_ext, sum;
   logic                       fill_last, last_tap, emit, last_win, band_end;

   assign pix     = win_col[tap_c][tap_r*BIT_DEPTH +: BIT_DEPTH];
   assign pix_ext = signed'(ACC_W'(pix));
   assign wt_ext  = ACC_W'(signed'(kernel_in));
   assign sum     = acc + pix_ext * wt_ext;

   assign n_win     = s2_q ? WW'(N2) : WW'(N1);
   assign need_m1   = (win_idx == '0) ? FW'(KSIZE - 1) : (s2_q ? FW'(1) : FW'(0));
   assign fill_last = (fill_cnt == need_m1);
   assign last_tap  = (kernel_addr == TW'(KK - 1));
   assign emit      = !pool_q || win_idx[0];
   assign last_win  = ((win_idx + WW'(1)) == n_win);
   assign band_end  = (win_idx == n_win);

   assign in_ready  = (state == S_FILL);
   assign out_valid = (state == S_WRITE);
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);

   always_comb begin
      res = sum[BIT_DEPTH-1:0];
      if (relu_q) begin
         if (sum < 0)         res = '0;
         else if (sum > UMAX) res = '1;
      end else begin
         if (sum > SMAX)      res = SMAX[BIT_DEPTH-1:0];
         else if (sum < SMIN) res = SMIN[BIT_DEPTH-1:0];
      end
   end

   // pooling compares in the output encoding: unsigned after ReLU, signed otherwise
   always_comb begin
      pooled = held;
      if (relu_q) begin
         if (res > held) pooled = res;
      end else begin
         if ($signed(res) > $signed(held)) pooled = res;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_FILL;
         S_FILL:  if (in_valid && fill_last) state_nxt = S_MAC;
         S_MAC: begin
            if (last_tap) begin
               if (emit)          state_nxt = S_WRITE;
               else if (last_win) state_nxt = S_DONE;
               else               state_nxt = S_FILL;
            end
         end
         S_WRITE: if (out_ready) state_nxt = band_end ? S_DONE : S_FILL;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         acc         <= '0;
         tap_r       <= '0;
         tap_c       <= '0;
         kernel_addr <= '0;
         fill_cnt    <= '0;
         win_idx     <= '0;
         s2_q        <= 1'b0;
         pool_q      <= 1'b0;
         relu_q      <= 1'b0;
         held        <= '0;
         out_data    <= '0;
         out_addr    <= '0;
         for (int i = 0; i < KSIZE; i++) win_col[i] <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               if (start) begin
                  s2_q     <= (stride == 2'd2);
                  pool_q   <= pool_en;
                  relu_q   <= relu_en;
                  out_addr <= in_dest_addr;
                  win_idx  <= '0;
                  fill_cnt <= '0;
               end
            end
            S_FILL: begin
               if (in_valid) begin
                  for (int i = 0; i < KSIZE - 1; i++) win_col[i] <= win_col[i+1];
                  win_col[KSIZE-1] <= in_col;
                  if (fill_last) begin
                     fill_cnt    <= '0;
                     acc         <= '0;
                     kernel_addr <= '0;
                     tap_r       <= '0;
                     tap_c       <= '0;
                  end else begin
                     fill_cnt <= fill_cnt + FW'(1);
                  end
               end
            end
            S_MAC: begin
               if (last_tap) begin
                  acc         <= '0;
                  kernel_addr <= '0;
                  tap_r       <= '0;
                  tap_c       <= '0;
                  win_idx     <= win_idx + WW'(1);
                  if (pool_q && !win_idx[0]) held <= res;
                  if (emit) out_data <= pool_q ? pooled : res;
               end else begin
                  acc         <= sum;
                  kernel_addr <= kernel_addr + TW'(1);
                  if (tap_c == RW'(KSIZE - 1)) begin
                     tap_c <= '0;
                     tap_r <= tap_r + RW'(1);
                  end else begin
                     tap_c <= tap_c + RW'(1);
                  end
               end
            end
            S_WRITE: if (out_ready) out_addr <= out_addr + ADDR_W'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_engine.sv
// Scoreboard bench for conv_engine: a plain-arithmetic band model queues expected
// (address, data) pairs; a negedge monitor pops and compares on every output handshake.
module tb_conv_engine;
   localparam int B  = 8;
   localparam int K  = 3;
   localparam int W  = 8;
   localparam int AW = 5;
   localparam int KK = K * K;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           start = 1'b0;
   logic [1:0]     stride = 2'd0;
   logic           pool_en = 1'b0;
   logic           relu_en = 1'b0;
   logic [AW-1:0]  in_dest_addr = '0;
   logic [K*B-1:0] in_col = '0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [3:0]     kernel_addr;
   logic [B-1:0]   kernel_in;
   logic [B-1:0]   out_data;
   logic [AW-1:0]  out_addr;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic           busy;
   logic           done;

   conv_engine #(.BIT_DEPTH(B), .KSIZE(K), .IMG_WIDTH(W), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .stride(stride), .pool_en(pool_en),
      .relu_en(relu_en), .in_dest_addr(in_dest_addr), .in_col(in_col),
      .in_valid(in_valid), .in_ready(in_ready), .kernel_addr(kernel_addr),
      .kernel_in(kernel_in), .out_data(out_data), .out_addr(out_addr),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {int addr; int data;} exp_t;

   int               vectors = 0;
   int               miscompares = 0;
   logic signed [7:0] wts [KK];
   int               pix [W][K];
   exp_t             sb [$];
   int               cyc = 0;
   int               xfer_cyc = 0;
   int               done_cnt = 0;
   int               ready_mode = 0;
   int               stall_cnt = 0;
   logic             pv_stall = 1'b0;
   logic             p_done = 1'b0;
   logic             p_valid = 1'b0;
   logic [B-1:0]     p_data = '0;
   logic [AW-1:0]    p_addr = '0;

   assign kernel_in = (kernel_addr < 4'd9) ? wts[kernel_addr] : 8'h00;

   task automatic chk(input string nm, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (in_valid && in_ready) xfer_cyc <= cyc;
   end

   // ready generator and monitor share one process so the handshake seen is the one driven
   always @(negedge clk) begin : mon
      exp_t e;
      if (ready_mode == 0) out_ready = 1'b1;
      else if (ready_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
      else if (out_valid) begin
         if (stall_cnt < 5) begin out_ready = 1'b0; stall_cnt++; end
         else out_ready = 1'b1;
      end else begin
         stall_cnt = 0;
         out_ready = 1'b1;
      end
      if (rst) begin
         if (pv_stall) begin
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_data", int'(out_data), int'(p_data));
            chk("stall_addr", int'(out_addr), int'(p_addr));
         end
         if (out_valid) chk("in_ready_in_write", int'(in_ready), 0);
         if (out_valid && !p_valid) chk("latency", cyc - xfer_cyc, KK + 1);
         if (p_done) chk("done_one_cycle", int'(done), 0);
         if (done) done_cnt++;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_output: addr %0d data %0d, expected no output", out_addr, out_data);
            end else begin
               e = sb.pop_front();
               chk("out_addr", int'(out_addr), e.addr);
               chk("out_data", int'(out_data), e.data);
            end
         end
      end
      pv_stall = rst && out_valid && !out_ready;
      p_data   = out_data;
      p_addr   = out_addr;
      p_done   = rst && done;
      p_valid  = out_valid;
   end

   function automatic int post(input int s, input bit relu);
      if (relu) return (s < 0) ? 0 : ((s > 255) ? 255 : s);
      return (s < -128) ? -128 : ((s > 127) ? 127 : s);
   endfunction

   task automatic model_band(input int s, input bit pool, input bit relu, input int dest);
      int n;
      int held;
      int addr;
      int v;
      int acc;
      n = (W - K) / s + 1;
      held = 0;
      addr = dest;
      for (int w = 0; w < n; w++) begin
         acc = 0;
         for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
               acc += pix[w*s + c][r] * int'(wts[r*K + c]);
         v = post(acc, relu);
         if (!pool || (w % 2 == 1)) begin
            if (pool && held > v) v = held;
            sb.push_back('{addr % 32, v & 255});
            addr++;
         end else begin
            held = v;
         end
      end
   endtask

   task automatic set_pix(input int mode, input int val);
      for (int c = 0; c < W; c++)
         for (int r = 0; r < K; r++)
            pix[c][r] = (mode == 0) ? val : ((mode == 1) ? c : int'($urandom_range(0, 255)));
   endtask

   task automatic set_wts(input int mode, input int val);
      for (int t = 0; t < KK; t++)
         wts[t] = (mode == 0) ? val[7:0] : 8'($urandom_range(0, 255));
   endtask

   task automatic send_col(input int c, input bit gaps);
      int t;
      int v;
      t = 0;
      if (gaps) repeat ($urandom_range(0, 2)) begin in_valid = 1'b0; @(negedge clk); end
      for (int r = 0; r < K; r++) begin
         v = pix[c][r];
         in_col[r*B +: B] = v[7:0];
      end
      in_valid = 1'b1;
      while (!in_ready && t < 200) begin @(negedge clk); t++; end
      if (!in_ready) begin
         vectors++;
         miscompares++;
         $display("FAIL in_ready_timeout: got 0 after %0d cycles, expected 1", t);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic run_band(input logic [1:0] sc, input bit pool, input bit relu, input int dest, input bit gaps);
      int s;
      int ncols;
      int d0;
      int t;
      s = (sc == 2'd2) ? 2 : 1;
      ncols = K + ((W - K) / s) * s;
      d0 = done_cnt;
      model_band(s, pool, relu, dest);
      @(negedge clk);
      stride = sc; pool_en = pool; relu_en = relu; in_dest_addr = dest[AW-1:0]; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < ncols; c++) send_col(c, gaps);
      t = 0;
      while (done_cnt == d0 && t < 2000) begin @(negedge clk); t++; end
      chk("done_count", done_cnt - d0, 1);
      chk("sb_drained", sb.size(), 0);
      sb.delete();
   endtask

   initial begin
      int t;
      set_wts(0, 1);
      set_pix(0, 1);
      repeat (3) @(negedge clk);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_kernel_addr", int'(kernel_addr), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_addr", int'(out_addr), 0);
      rst = 1'b1;
      @(negedge clk);

      run_band(2'd1, 1'b0, 1'b1, 4, 1'b0);
      run_band(2'd2, 1'b0, 1'b1, 4, 1'b0);
      set_pix(0, 255); set_wts(0, 127);
      run_band(2'd1, 1'b0, 1'b1, 7, 1'b0);
      set_wts(0, -1);
      run_band(2'd1, 1'b0, 1'b1, 0, 1'b0);
      run_band(2'd0, 1'b0, 1'b0, 0, 1'b0);
      set_pix(1, 0); set_wts(0, 1);
      run_band(2'd1, 1'b1, 1'b1, 10, 1'b0);
      set_pix(2, 0); set_wts(2, 0);
      run_band(2'd2, 1'b1, 1'b0, 31, 1'b0);

      ready_mode = 2;
      run_band(2'd1, 1'b0, 1'b1, 3, 1'b1);

      ready_mode = 1;
      for (int i = 0; i < 10; i++) begin
         set_pix(2, 0); set_wts(2, 0);
         run_band(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), 1'b1);
      end
      ready_mode = 0;

      // abandon a band with reset in the middle of the first MAC
      set_pix(2, 0); set_wts(2, 0);
      @(negedge clk);
      stride = 2'd1; pool_en = 1'b0; relu_en = 1'b1; in_dest_addr = 5'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < K; c++) send_col(c, 1'b0);
      t = 0;
      while (kernel_addr != 4'd4 && t < 100) begin @(negedge clk); t++; end
      chk("mac_tap4_reached", int'(kernel_addr), 4);
      rst = 1'b0;
      #1;
      chk("mid_rst_in_ready", int'(in_ready), 0);
      chk("mid_rst_out_valid", int'(out_valid), 0);
      chk("mid_rst_done", int'(done), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_kernel_addr", int'(kernel_addr), 0);
      chk("mid_rst_out_data", int'(out_data), 0);
      chk("mid_rst_out_addr", int'(out_addr), 0);
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b1;
      repeat (20) begin
         @(negedge clk);
         chk("post_rst_out_valid", int'(out_valid), 0);
         chk("post_rst_busy", int'(busy), 0);
         chk("post_rst_in_ready", int'(in_ready), 0);
      end
      in_valid = 1'b0;
      chk("post_rst_sb_empty", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
